// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares one register-file write port between the WB stage and a 2-entry multi-cycle result buffer
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_we,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        mc_valid,
  input  logic [4:0]  mc_reg,
  input  logic [31:0] mc_data,
  output logic        mc_ready,
  input  logic [4:0]  rd_a,
  input  logic [4:0]  rd_b,
  output logic        hazard,
  output logic        rf_we,
  output logic [4:0]  rf_reg,
  output logic [31:0] rf_data,
  output logic        stall
);
  logic        r_valid [2];
  logic        r_kill  [2];
  logic [4:0]  r_reg   [2];
  logic [31:0] r_data  [2];
  logic        r_wp;
  logic        r_rp;
  logic [1:0]  r_cnt;
  logic [3:0]  r_starve;
  logic        r_stall;
  logic        w_ready;
  logic        w_grant;
  logic        w_deq;
  logic        w_enq;
  logic        w_starved;
  logic        w_head_we;
  logic        w_hazard;

  // WB wins the port unless stalled; the buffer head drains whenever WB does not take it
  always_comb begin
    w_ready   = r_cnt < 2'd2;
    w_grant   = !r_stall && wb_we && wb_reg != 5'd0;
    w_deq     = !w_grant && r_cnt != 2'd0;
    w_enq     = mc_valid && w_ready;
    w_starved = w_grant && r_cnt != 2'd0;
    w_head_we = !r_kill[r_rp] && r_reg[r_rp] != 5'd0;
  end

  // hazard looks only at stored, still-live entries; the incoming result is not yet visible
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < 2; i++)
      w_hazard = w_hazard | (r_valid[i] && !r_kill[i] &&
                 ((rd_a != 5'd0 && rd_a == r_reg[i]) || (rd_b != 5'd0 && rd_b == r_reg[i])));
  end

  // outputs are forced quiet while reset is asserted, independent of the inputs
  always_comb begin
    mc_ready = rst_n && w_ready;
    hazard   = rst_n && w_hazard;
    rf_we    = rst_n && (w_grant || (w_deq && w_head_we));
    rf_reg   = !rst_n ? 5'd0  : w_grant ? wb_reg  : w_deq ? r_reg[r_rp]  : 5'd0;
    rf_data  = !rst_n ? 32'd0 : w_grant ? wb_data : w_deq ? r_data[r_rp] : 32'd0;
    stall    = r_stall;
  end

  // FIFO storage, WAW kill marking, starvation counting and the one-cycle stall pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_valid[i] <= 1'b0;
        r_kill[i]  <= 1'b0;
        r_reg[i]   <= 5'd0;
        r_data[i]  <= 32'd0;
      end
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
      r_starve <= 4'd0;
      r_stall  <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (w_grant && r_valid[i] && r_reg[i] == wb_reg) r_kill[i] <= 1'b1;
      if (w_deq) begin
        r_valid[r_rp] <= 1'b0;
        r_kill[r_rp]  <= 1'b0;
        r_rp          <= ~r_rp;
      end
      if (w_enq) begin
        r_valid[r_wp] <= 1'b1;
        r_kill[r_wp]  <= w_grant && wb_reg == mc_reg;
        r_reg[r_wp]   <= mc_reg;
        r_data[r_wp]  <= mc_data;
        r_wp          <= ~r_wp;
      end
      r_cnt    <= r_cnt + {1'b0, w_enq} - {1'b0, w_deq};
      r_starve <= w_starved ? r_starve + 4'd1 : 4'd0;
      r_stall  <= w_starved && r_starve == 4'(STARVE_LIMIT - 1);
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed vectors with hand-computed expectations for wb_port_arbiter
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_reg = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        mc_valid = 1'b0;
  logic [4:0]  mc_reg = 5'd0;
  logic [31:0] mc_data = 32'd0;
  logic        mc_ready;
  logic [4:0]  rd_a = 5'd0;
  logic [4:0]  rd_b = 5'd0;
  logic        hazard;
  logic        rf_we;
  logic [4:0]  rf_reg;
  logic [31:0] rf_data;
  logic        stall;
  int          n_pass = 0;
  int          n_tot = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
    .mc_valid(mc_valid), .mc_reg(mc_reg), .mc_data(mc_data), .mc_ready(mc_ready),
    .rd_a(rd_a), .rd_b(rd_b), .hazard(hazard),
    .rf_we(rf_we), .rf_reg(rf_reg), .rf_data(rf_data), .stall(stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [31:0] we, input logic [31:0] r, input logic [31:0] d);
    wb_we = we[0];
    wb_reg = r[4:0];
    wb_data = d;
  endtask

  task automatic mc(input logic [31:0] v, input logic [31:0] r, input logic [31:0] d);
    mc_valid = v[0];
    mc_reg = r[4:0];
    mc_data = d;
  endtask

  task automatic port(input string tag, input logic [31:0] we, input logic [31:0] r, input logic [31:0] d);
    chk({tag, "_we"}, 32'(rf_we), we);
    chk({tag, "_reg"}, 32'(rf_reg), r);
    chk({tag, "_data"}, rf_data, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    wb(1, 5, 32'h1234); mc(1, 5, 32'hDEADBEEF); rd_a = 5'd5;
    #2;
    port("rst", 0, 0, 0);
    chk("rst_ready", 32'(mc_ready), 0);
    chk("rst_hazard", 32'(hazard), 0);
    chk("rst_stall", 32'(stall), 0);
    nxt; rst_n = 1'b1; wb(0, 0, 0); mc(1, 5, 32'hDEADBEEF); rd_a = 5'd0; #1;
    chk("idle_ready", 32'(mc_ready), 1);
    port("idle_c0", 0, 0, 0);
    nxt; mc(0, 0, 0); #1;
    port("idle_c1", 1, 5, 32'hDEADBEEF);
    nxt; #1;
    port("idle_c2", 0, 0, 0);
    nxt; wb(1, 20, 32'hAAAA); mc(1, 1, 32'h11); #1;
    chk("bp_ready0", 32'(mc_ready), 1);
    port("bp_c0", 1, 20, 32'hAAAA);
    nxt; mc(1, 2, 32'h22); #1;
    chk("bp_ready1", 32'(mc_ready), 1);
    port("bp_c1", 1, 20, 32'hAAAA);
    nxt; mc(1, 3, 32'h33); rd_a = 5'd1; rd_b = 5'd2; #1;
    chk("bp_full_ready", 32'(mc_ready), 0);
    chk("bp_hazard", 32'(hazard), 1);
    port("bp_c2", 1, 20, 32'hAAAA);
    nxt; wb(0, 0, 0); #1;
    chk("bp_deq_full_ready", 32'(mc_ready), 0);
    port("bp_d1", 1, 1, 32'h11);
    nxt; #1;
    chk("bp_ready_again", 32'(mc_ready), 1);
    port("bp_d2", 1, 2, 32'h22);
    nxt; mc(0, 0, 0); #1;
    port("bp_d3", 1, 3, 32'h33);
    nxt; #1;
    port("bp_empty", 0, 0, 0);
    chk("bp_hazard_clr", 32'(hazard), 0);
    chk("bp_stall", 32'(stall), 0);
    rd_a = 5'd0; rd_b = 5'd0;
    nxt; mc(1, 7, 32'h77); #1;
    port("sv_enq", 0, 0, 0);
    nxt; mc(0, 0, 0); wb(1, 3, 32'h33); rd_a = 5'd7; #1;
    chk("sv_hazard", 32'(hazard), 1);
    port("sv_d1", 1, 3, 32'h33);
    nxt; #1;
    chk("sv_d2_stall", 32'(stall), 0);
    nxt; #1;
    chk("sv_d3_stall", 32'(stall), 0);
    nxt; #1;
    chk("sv_d4_stall", 32'(stall), 0);
    port("sv_d4", 1, 3, 32'h33);
    nxt; #1;
    chk("sv_stall", 32'(stall), 1);
    port("sv_drain", 1, 7, 32'h77);
    nxt; #1;
    chk("sv_unstall", 32'(stall), 0);
    chk("sv_hazard_clr", 32'(hazard), 0);
    port("sv_resume", 1, 3, 32'h33);
    nxt; wb(0, 0, 0); mc(1, 9, 32'h1); rd_a = 5'd0; #1;
    port("waw_enq", 0, 0, 0);
    nxt; mc(0, 0, 0); wb(1, 9, 32'h2); rd_a = 5'd9; #1;
    chk("waw_hazard", 32'(hazard), 1);
    port("waw_wb", 1, 9, 32'h2);
    nxt; wb(0, 0, 0); #1;
    chk("waw_hazard_kill", 32'(hazard), 0);
    port("waw_drain", 0, 9, 32'h1);
    nxt; wb(1, 12, 32'h5); mc(1, 12, 32'h6); rd_a = 5'd0; rd_b = 5'd12; #1;
    chk("waw_same_hazard", 32'(hazard), 0);
    port("waw_same_wb", 1, 12, 32'h5);
    nxt; wb(0, 0, 0); mc(0, 0, 0); #1;
    chk("waw_same_hazard2", 32'(hazard), 0);
    port("waw_same_drain", 0, 12, 32'h6);
    nxt; rd_b = 5'd0; mc(1, 0, 32'hF0); #1;
    chk("r0_ready", 32'(mc_ready), 1);
    nxt; mc(0, 0, 0); #1;
    port("r0_drain", 0, 0, 32'hF0);
    nxt; mc(1, 4, 32'h44); #1;
    nxt; mc(1, 6, 32'h66); wb(1, 20, 32'hBB); rd_a = 5'd4; #1;
    port("rs_wb0", 1, 20, 32'hBB);
    nxt; mc(0, 0, 0); #1;
    chk("rs_hazard", 32'(hazard), 1);
    chk("rs_full", 32'(mc_ready), 0);
    #1 rst_n = 1'b0; #1;
    port("rs_mid", 0, 0, 0);
    chk("rs_mid_ready", 32'(mc_ready), 0);
    chk("rs_mid_hazard", 32'(hazard), 0);
    nxt; #1;
    port("rs_held", 0, 0, 0);
    nxt; rst_n = 1'b1; wb(0, 0, 0); #1;
    chk("rs_ready_first", 32'(mc_ready), 1);
    chk("rs_hazard_after", 32'(hazard), 0);
    port("rs_after0", 0, 0, 0);
    nxt; #1;
    port("rs_after1", 0, 0, 0);
    nxt; #1;
    port("rs_after2", 0, 0, 0);
    chk("rs_stall", 32'(stall), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The block SHALL have one parameter: STARVE_LIMIT, default 4, the number of consecutive cycles the buffer head may be denied the write port before a stall is forced (legal range 2..15).
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port wb_we, input, 1 bit: the pipeline WB stage requests a register write this cycle.
REQ-005 Port wb_reg, input, 5 bits: WB destination register.
REQ-006 Port wb_data, input, 32 bits: WB write data.
REQ-007 Port mc_valid, input, 1 bit: the multi-cycle unit offers a result.
REQ-008 Port mc_reg, input, 5 bits: multi-cycle result destination register.
REQ-009 Port mc_data, input, 32 bits: multi-cycle result data.
REQ-010 Port mc_ready, output, 1 bit: the block accepts a result this cycle.
REQ-011 Ports rd_a and rd_b, input, 5 bits each: decode-stage source registers.
REQ-012 Port hazard, output, 1 bit: a source register has a pending buffered write.
REQ-013 Ports rf_we (1 bit), rf_reg (5 bits) and rf_data (32 bits), outputs: the single register-file write port.
REQ-014 Port stall, output, 1 bit, registered: the pipeline SHALL hold its WB stage while this is high.

Function
REQ-015 The block SHALL hold a 2-entry in-order FIFO of {valid, kill, reg, data}.
REQ-016 mc_ready SHALL equal 1 when the FIFO count is below 2, from current state only; the block SHALL enqueue on mc_valid && mc_ready.
REQ-017 When the FIFO is full, mc_ready SHALL be 0, even if a dequeue occurs in the same cycle.
REQ-018 An entry enqueued in cycle N SHALL NOT be dequeued before cycle N+1; there is no bypass path.
REQ-019 Grant rule, combinational: if stall=0 and wb_we=1 and wb_reg!=0, the port SHALL carry wb_reg/wb_data with rf_we=1.
REQ-020 Otherwise, if the FIFO is non-empty, the head SHALL be dequeued; rf_we SHALL be 1 only if the head is not killed and its reg!=0, and rf_reg/rf_data SHALL carry the head.
REQ-021 Otherwise rf_we SHALL be 0, and rf_reg/rf_data SHALL be 0.
REQ-022 While stall=1, the wb_* inputs SHALL be ignored; the pipeline repeats the write after the stall.
REQ-023 WAW: a granted WB write SHALL set the kill bit of every valid FIFO entry with a matching reg.
REQ-024 WAW: an entry enqueued in the same cycle with a matching reg SHALL be stored killed.
REQ-025 Writes to register 0, from either source, SHALL never assert rf_we; such entries are still enqueued and drained.
REQ-026 A starvation counter SHALL increment on each cycle in which the FIFO is non-empty and WB holds the port.
REQ-027 The starvation counter SHALL clear on any dequeue or when the FIFO is empty.
REQ-028 stall SHALL be set on the edge at which the counter reaches STARVE_LIMIT-1 while still denied.
REQ-029 stall SHALL remain high for exactly one cycle, during which the head drains; the counter SHALL then clear.
REQ-030 hazard SHALL be 1 iff rd_a or rd_b is nonzero and equals the reg of a valid, non-killed FIFO entry; the same-cycle incoming mc result is excluded.
REQ-031 Count update per cycle SHALL be +1 (enqueue only), -1 (dequeue only) or 0 (both or neither); the pointers SHALL wrap modulo 2.

Reset
REQ-032 While rst_n=0, the block SHALL hold: FIFO count 0, all entries invalid and kill=0, pointers 0, starvation counter 0, stall 0.
REQ-033 While rst_n=0, the outputs SHALL read rf_we=0, rf_reg=0, rf_data=0, hazard=0 and mc_ready=0, regardless of the inputs.
REQ-034 A reset asserted mid-operation SHALL discard all buffered results without any write.
REQ-035 After rst_n rises, mc_ready SHALL be 1 in the first cycle.

Verification
REQ-036 Idle port: mc result r5=0xDEADBEEF in cycle 0 with wb_we=0 -> rf_we=1, rf_reg=5, rf_data=0xDEADBEEF in cycle 1, and none in cycle 0.
REQ-037 Backpressure: three back-to-back mc results with wb_we held 1 (r1,r2 targets) -> mc_ready=0 after two accepts; the third is held by the source; no loss and in-order drain.
REQ-038 Starvation: FIFO holds r7 and WB writes r3 every cycle -> stall=1 on the 4th denied cycle's following edge; r7 is written in the stall cycle; the r3 write is ignored then resumes.
REQ-039 WAW kill: FIFO holds r9=0x1 and WB writes r9=0x2 -> r9 receives 0x2; the drained entry produces rf_we=0; hazard on rd_a=9 drops to 0 after the kill.
REQ-040 r0 and reset: mc result to r0 -> drained with rf_we=0; then two entries buffered and rst_n pulsed low mid-cycle -> the outputs clear immediately and no buffered write ever appears.
